// File: rtl/awgn_noise_mult_if.sv
// Sample-pair bus for the final Box-Muller stage: radius and sin/cos inputs
// from upstream, and the buffered valid/ready Gaussian output.
interface awgn_noise_mult_if #(
    parameter int LEVEL_W = 3
);
    logic [15:0]        f_e;
    logic [15:0]        g0;
    logic [15:0]        g1;
    logic               g_valid;
    logic               out_ready;
    logic               out_valid;
    logic [15:0]        x0;
    logic [15:0]        x1;
    logic [15:0]        drop_cnt;
    logic [LEVEL_W-1:0] fifo_level;

    // Upstream producer / downstream consumer side
    modport master (
        output f_e, g0, g1, g_valid, out_ready,
        input  out_valid, x0, x1, drop_cnt, fifo_level
    );

    // The noise multiplier itself
    modport slave (
        input  f_e, g0, g1, g_valid, out_ready,
        output out_valid, x0, x1, drop_cnt, fifo_level
    );
endinterface

// File: rtl/awgn_noise_mult.sv
// Final Box-Muller stage: x = f_e * (+/-g), rounded to Q4.11 two's complement,
// buffered in a small first-word-fall-through FIFO with a drop counter.
module awgn_noise_mult #(
    parameter int F_DELAY    = 3,
    parameter int OUT_SHIFT  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    awgn_noise_mult_if.slave  bus
);
    localparam int K     = 17 + OUT_SHIFT;
    // Only product bits [30:K-1] influence the rounded result, so S1 keeps those.
    localparam int P_W   = 32 - K;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    // ---------------- f_e alignment delay line ----------------
    logic [15:0] f_d;

    if (F_DELAY == 0) begin : g_no_delay
        assign f_d = bus.f_e;
    end else begin : g_delay
        logic [15:0] dly_q [F_DELAY];

        // Shift f_e down the delay line every cycle.
        // NOTE: sequential state uses non-blocking (<=) so every stage samples the pre-edge value.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < F_DELAY; i++) dly_q[i] <= '0;
            end else begin
                dly_q[0] <= bus.f_e;
                for (int i = 1; i < F_DELAY; i++) dly_q[i] <= dly_q[i-1];
            end
        end

        assign f_d = dly_q[F_DELAY-1];
    end

    // ---------------- S1: magnitude products ----------------
    logic [P_W-1:0] pk0_d, pk1_d, pk0_q, pk1_q;
    logic           s0_q, s1_q, v1_q;

    assign pk0_d = P_W'(({15'd0, f_d} * {16'd0, bus.g0[14:0]}) >> (K - 1));
    assign pk1_d = P_W'(({15'd0, f_d} * {16'd0, bus.g1[14:0]}) >> (K - 1));

    // Register the truncated products with their signs and valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pk0_q <= '0;
            pk1_q <= '0;
            s0_q  <= 1'b0;
            s1_q  <= 1'b0;
            v1_q  <= 1'b0;
        end else begin
            pk0_q <= pk0_d;
            pk1_q <= pk1_d;
            s0_q  <= bus.g0[15];
            s1_q  <= bus.g1[15];
            v1_q  <= bus.g_valid;
        end
    end

    // ---------------- S2: round half up, apply sign ----------------
    logic [15:0] m0, m1, x0_s2_d, x1_s2_d, x0_s2_q, x1_s2_q;
    logic        v2_q;

    // Round on bit K-1 and negate for a set sign bit; -0 collapses to 0.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        m0      = 16'({1'b0, pk0_q[P_W-1:1]}) + 16'(pk0_q[0]);
        m1      = 16'({1'b0, pk1_q[P_W-1:1]}) + 16'(pk1_q[0]);
        x0_s2_d = s0_q ? (16'd0 - m0) : m0;
        x1_s2_d = s1_q ? (16'd0 - m1) : m1;
    end

    // Register the signed samples and their valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x0_s2_q <= '0;
            x1_s2_q <= '0;
            v2_q    <= 1'b0;
        end else begin
            x0_s2_q <= x0_s2_d;
            x1_s2_q <= x1_s2_d;
            v2_q    <= v1_q;
        end
    end

    // ---------------- Output FIFO ----------------
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic [15:0]      drop_q, drop_d;
    logic [31:0]      last_q, last_d;
    logic             pop, push_acc, drop;

    // Handshake decode and next-state for pointers, level, drop count and hold value.
    always_comb begin
        pop      = (count_q != '0) && bus.out_ready;
        push_acc = v2_q && ((count_q != FULL_LVL) || pop);
        drop     = v2_q && (count_q == FULL_LVL) && !pop;
        wr_ptr_d = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        drop_d   = (drop && (drop_q != 16'hFFFF)) ? drop_q + 1'b1 : drop_q;
        last_d   = pop ? mem_q[rd_ptr_q] : last_q;
    end

    // FIFO control state; reset flushes everything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            last_q   <= last_d;
        end
    end

    // Store accepted pairs.
    // NOTE: storage is not reset; the level counter decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= {x0_s2_q, x1_s2_q};
    end

    assign bus.out_valid  = (count_q != '0);
    assign bus.fifo_level = count_q;
    assign bus.drop_cnt   = drop_q;
    assign bus.x0         = bus.out_valid ? mem_q[rd_ptr_q][31:16] : last_q[31:16];
    assign bus.x1         = bus.out_valid ? mem_q[rd_ptr_q][15:0]  : last_q[15:0];
endmodule
